// File: rtl/prod_accum_if.sv
// prod_accum_if: product input stream plus result output stream of the accumulator
//   in_valid/in_ready/in_prod/in_last : upstream product beats
//   out_valid/out_ready               : result handshake
//   out_acc/out_count/out_ovf         : registered dot-product result, beat count, sticky overflow
interface prod_accum_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/prod_accum_unit.sv
// prod_accum_unit: sums a stream of 16-bit products and presents the total on a registered handshake
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   clear : synchronous abort of partial sum and any held result
//   bus   : prod_accum_if slave (product beats in, result out)
module prod_accum_unit #(
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clear,
  prod_accum_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, oacc_q, oacc_d, acc_upd;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_upd;
  logic             ovf_q, ovf_d, oovf_q, oovf_d, ovld_q, ovld_d, ovf_upd;
  logic [ACC_W:0]   sum;
  logic             accept;
  assign bus.in_ready  = rst_n & (state_q != HOLD);
  assign bus.out_valid = ovld_q;
  assign bus.out_acc   = oacc_q;
  assign bus.out_count = ocnt_q;
  assign bus.out_ovf   = oovf_q;
  assign accept  = bus.in_valid & bus.in_ready;
  assign sum     = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, bus.in_prod};
  assign acc_upd = (sum[ACC_W] && SATURATE != 0) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign ovf_upd = ovf_q | sum[ACC_W];
  // beat count sticks at all-ones rather than wrapping
  assign cnt_upd = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovld_d  = ovld_q;
    oacc_d  = oacc_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      ovld_d  = 1'b0;
    end else if (accept && bus.in_last) begin
      state_d = HOLD;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      ovld_d  = 1'b1;
      oacc_d  = acc_upd;
      ocnt_d  = cnt_upd;
      oovf_d  = ovf_upd;
    end else if (accept) begin
      state_d = ACCUM;
      acc_d   = acc_upd;
      cnt_d   = cnt_upd;
      ovf_d   = ovf_upd;
    end else if (ovld_q && bus.out_ready) begin
      state_d = IDLE;
      ovld_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ovld_q  <= 1'b0;
      oacc_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ovld_q  <= ovld_d;
      oacc_q  <= oacc_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule

// File: tb/tb_prod_accum_unit.sv
// tb_prod_accum_unit: four configurations driven by one shared stimulus, checked against hand-computed results
module tb_prod_accum_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  int          n_pass = 0;
  int          n_tot = 0;
  always #5 clk = ~clk;
  prod_accum_if #(.ACC_W(32), .CNT_W(8)) if_a ();
  prod_accum_if #(.ACC_W(17), .CNT_W(8)) if_s ();
  prod_accum_if #(.ACC_W(17), .CNT_W(8)) if_w ();
  prod_accum_if #(.ACC_W(32), .CNT_W(2)) if_c ();
  assign if_a.in_valid = in_valid;
  assign if_a.in_prod = in_prod;
  assign if_a.in_last = in_last;
  assign if_a.out_ready = out_ready;
  assign if_s.in_valid = in_valid;
  assign if_s.in_prod = in_prod;
  assign if_s.in_last = in_last;
  assign if_s.out_ready = out_ready;
  assign if_w.in_valid = in_valid;
  assign if_w.in_prod = in_prod;
  assign if_w.in_last = in_last;
  assign if_w.out_ready = out_ready;
  assign if_c.in_valid = in_valid;
  assign if_c.in_prod = in_prod;
  assign if_c.in_last = in_last;
  assign if_c.out_ready = out_ready;
  prod_accum_unit #(.ACC_W(32), .CNT_W(8), .SATURATE(1)) u_a (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_a));
  prod_accum_unit #(.ACC_W(17), .CNT_W(8), .SATURATE(1)) u_s (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s));
  prod_accum_unit #(.ACC_W(17), .CNT_W(8), .SATURATE(0)) u_w (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_w));
  prod_accum_unit #(.ACC_W(32), .CNT_W(2), .SATURATE(1)) u_c (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_c));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [15:0] p, input logic last);
    chk("in_ready_before_beat", if_a.in_ready, 1);
    in_valid = 1'b1;
    in_prod = p;
    in_last = last;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic handshake();
    step();
    chk("out_valid_after_hs", if_a.out_valid, 0);
    chk("in_ready_after_hs", if_a.in_ready, 1);
  endtask
  initial begin
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", if_a.in_ready, 0);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_out_acc", if_a.out_acc, 0);
    chk("rst_out_count", if_a.out_count, 0);
    chk("rst_out_ovf", if_a.out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", if_a.in_ready, 1);
    // basic sum: 4 x 65025
    for (int i = 0; i < 4; i++) beat(16'd65025, i == 3);
    chk("basic_valid", if_a.out_valid, 1);
    chk("basic_in_ready", if_a.in_ready, 0);
    chk("basic_acc", if_a.out_acc, 260100);
    chk("basic_cnt", if_a.out_count, 4);
    chk("basic_ovf", if_a.out_ovf, 0);
    chk("basic_sat_acc", if_s.out_acc, 131071);
    chk("basic_sat_ovf", if_s.out_ovf, 1);
    chk("basic_wrap_acc", if_w.out_acc, 129028);
    chk("basic_wrap_ovf", if_w.out_ovf, 1);
    chk("basic_c2_cnt", if_c.out_count, 3);
    handshake();
    chk("basic_acc_kept", if_a.out_acc, 260100);
    // backpressure with upstream holding a pending beat
    out_ready = 1'b0;
    beat(16'd100, 0);
    beat(16'd200, 0);
    beat(16'd300, 1);
    in_valid = 1'b1;
    in_prod = 16'd7;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", if_a.out_valid, 1);
      chk("bp_in_ready", if_a.in_ready, 0);
      chk("bp_acc", if_a.out_acc, 600);
      chk("bp_cnt", if_a.out_count, 3);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_hold_acc", if_a.out_acc, 600);
    step();
    chk("bp_hs_valid", if_a.out_valid, 0);
    chk("bp_hs_in_ready", if_a.in_ready, 1);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("bp2_valid", if_a.out_valid, 1);
    chk("bp2_acc", if_a.out_acc, 7);
    chk("bp2_cnt", if_a.out_count, 1);
    handshake();
    // saturation / wrap: 3 x 65025
    for (int i = 0; i < 3; i++) beat(16'd65025, i == 2);
    chk("sat_acc", if_s.out_acc, 131071);
    chk("sat_ovf", if_s.out_ovf, 1);
    chk("sat_cnt", if_s.out_count, 3);
    chk("wrap_acc", if_w.out_acc, 64003);
    chk("wrap_ovf", if_w.out_ovf, 1);
    chk("wide_acc", if_a.out_acc, 195075);
    chk("wide_ovf", if_a.out_ovf, 0);
    handshake();
    beat(16'd5, 1);
    chk("sat_next_acc", if_s.out_acc, 5);
    chk("sat_next_ovf", if_s.out_ovf, 0);
    chk("wrap_next_acc", if_w.out_acc, 5);
    chk("wrap_next_ovf", if_w.out_ovf, 0);
    handshake();
    // counter saturation: 5 x 1
    for (int i = 0; i < 5; i++) beat(16'd1, i == 4);
    chk("cs_acc", if_c.out_acc, 5);
    chk("cs_cnt", if_c.out_count, 3);
    chk("cs_ovf", if_c.out_ovf, 0);
    chk("cs_wide_cnt", if_a.out_count, 5);
    handshake();
    // abort by clear coincident with the last beat
    beat(16'd10, 0);
    beat(16'd20, 0);
    clear = 1'b1;
    beat(16'd30, 1);
    clear = 1'b0;
    chk("clr_valid", if_a.out_valid, 0);
    chk("clr_in_ready", if_a.in_ready, 1);
    chk("clr_acc_kept", if_a.out_acc, 5);
    step();
    chk("clr_valid_later", if_a.out_valid, 0);
    beat(16'd40, 1);
    chk("clr_next_acc", if_a.out_acc, 40);
    chk("clr_next_cnt", if_a.out_count, 1);
    handshake();
    // abort by reset coincident with the last beat
    beat(16'd10, 0);
    beat(16'd20, 0);
    in_valid = 1'b1;
    in_prod = 16'd30;
    in_last = 1'b1;
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("rst2_valid", if_a.out_valid, 0);
    chk("rst2_acc", if_a.out_acc, 0);
    chk("rst2_cnt", if_a.out_count, 0);
    chk("rst2_in_ready", if_a.in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst2_valid_later", if_a.out_valid, 0);
    beat(16'd40, 1);
    chk("rst2_next_acc", if_a.out_acc, 40);
    chk("rst2_next_cnt", if_a.out_count, 1);
    chk("rst2_next_ovf", if_a.out_ovf, 0);
    handshake();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
